// File: rtl/pipelined_addsub.sv
// Segment-pipelined add/subtract: the carry chain is cut into NUM_SEGMENTS
// registered slices behind a stallable valid/ready shift pipeline.

module addsub_seg #(
  parameter int IN_W  = 4,
  parameter int OUT_W = IN_W + 1,
  parameter int SEG_W = 2,
  parameter int SEG   = 0,
  parameter bit LAST  = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             advance,
  input  logic             vld_i,
  input  logic [IN_W-1:0]  a_i,
  input  logic [IN_W-1:0]  b_i,
  input  logic             c_i,
  input  logic             sub_i,
  input  logic [OUT_W-1:0] r_i,
  output logic             vld_o,
  output logic [IN_W-1:0]  a_o,
  output logic [IN_W-1:0]  b_o,
  output logic             c_o,
  output logic             sub_o,
  output logic [OUT_W-1:0] r_o
);
  logic [SEG_W:0]   seg_sum;
  logic [OUT_W-1:0] r_nxt;

  always_comb begin
    seg_sum = {1'b0, a_i[SEG*SEG_W +: SEG_W]} + {1'b0, b_i[SEG*SEG_W +: SEG_W]}
            + (SEG_W+1)'(c_i);
    r_nxt = r_i;
    r_nxt[SEG*SEG_W +: SEG_W] = seg_sum[SEG_W-1:0];
    // Sub: the inverted zero-extension of in2 contributes a 1 at the top bit.
    if (LAST) r_nxt[IN_W] = sub_i ^ seg_sum[SEG_W];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_o <= 1'b0;
      a_o   <= '0;
      b_o   <= '0;
      c_o   <= 1'b0;
      sub_o <= 1'b0;
      r_o   <= '0;
    end else if (advance) begin
      vld_o <= vld_i;
      a_o   <= a_i;
      b_o   <= b_i;
      c_o   <= seg_sum[SEG_W];
      sub_o <= sub_i;
      r_o   <= r_nxt;
    end
  end
endmodule

module pipelined_addsub #(
  parameter int IN_DATAWIDTH  = 4,
  parameter int OUT_DATAWIDTH = IN_DATAWIDTH + 1,
  parameter int NUM_SEGMENTS  = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [IN_DATAWIDTH-1:0]  in1,
  input  logic [IN_DATAWIDTH-1:0]  in2,
  input  logic                     cin,
  input  logic                     sub,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [OUT_DATAWIDTH-1:0] sum
);
  localparam int SEG_W = IN_DATAWIDTH / NUM_SEGMENTS;

  logic                                        advance;
  logic [NUM_SEGMENTS:0]                       vld_pipe;
  logic [NUM_SEGMENTS:0][IN_DATAWIDTH-1:0]     a_pipe, b_pipe;
  logic [NUM_SEGMENTS:0]                       c_pipe, sub_pipe;
  logic [NUM_SEGMENTS:0][OUT_DATAWIDTH-1:0]    r_pipe;
  logic                                        unused_tail;

  // Bubbles shift too; only an untaken result at the output stalls the chain.
  assign advance  = !out_valid || out_ready;
  assign in_ready = advance;

  assign vld_pipe[0] = in_valid;
  assign a_pipe[0]   = in1;
  assign b_pipe[0]   = sub ? ~in2 : in2;
  assign c_pipe[0]   = cin ^ sub;
  assign sub_pipe[0] = sub;
  assign r_pipe[0]   = '0;

  for (genvar k = 0; k < NUM_SEGMENTS; k++) begin : g_seg
    addsub_seg #(
      .IN_W (IN_DATAWIDTH),
      .OUT_W(OUT_DATAWIDTH),
      .SEG_W(SEG_W),
      .SEG  (k),
      .LAST (k == NUM_SEGMENTS-1)
    ) u_seg (
      .clk    (clk),
      .rst_n  (rst_n),
      .advance(advance),
      .vld_i  (vld_pipe[k]),
      .a_i    (a_pipe[k]),
      .b_i    (b_pipe[k]),
      .c_i    (c_pipe[k]),
      .sub_i  (sub_pipe[k]),
      .r_i    (r_pipe[k]),
      .vld_o  (vld_pipe[k+1]),
      .a_o    (a_pipe[k+1]),
      .b_o    (b_pipe[k+1]),
      .c_o    (c_pipe[k+1]),
      .sub_o  (sub_pipe[k+1]),
      .r_o    (r_pipe[k+1])
    );
  end

  assign out_valid   = vld_pipe[NUM_SEGMENTS];
  assign sum         = r_pipe[NUM_SEGMENTS];
  assign unused_tail = ^{a_pipe[NUM_SEGMENTS], b_pipe[NUM_SEGMENTS],
                         c_pipe[NUM_SEGMENTS], sub_pipe[NUM_SEGMENTS]};
endmodule
